wb_bus_arbiter: RTL and testbench

- Round-robin arbiter sharing the 16-bit write-back bus between three requesters: ALU result, memory load data, and immediate/PC path.
- Owns the 2-bit select of the existing 3:1 16-bit operand mux: encoding 00=i1, 01=i2, 10=i3.
- Issues one-hot grants with a req/done handshake and a hold-time limit, so no single source can monopolise the bus.
- Sits between the RISC control unit and the write-back mux.

---
 rtl/wb_bus_pkg.sv | 30 +++
 rtl/wb_bus_arbiter_rr_pick3.sv | 33 +++
 rtl/wb_bus_arbiter.sv | 85 ++++++++
 tb/tb_wb_bus_arbiter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/wb_bus_pkg.sv
// ============================================================================
// Module   : wb_bus_pkg
// Brief    : Shared constants and helpers for the write-back bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_bus_pkg;

  localparam int unsigned NUM_SRC = 3;

  localparam logic IDLE = 1'b0;
  localparam logic BUSY = 1'b1;

  localparam logic [1:0] SEL_I1 = 2'b00;
  localparam logic [1:0] SEL_I2 = 2'b01;
  localparam logic [1:0] SEL_I3 = 2'b10;

  typedef logic [1:0] src_idx_t;

  function automatic logic [NUM_SRC-1:0] onehot3(input src_idx_t idx);
    logic [NUM_SRC-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_bus_arbiter_rr_pick3.sv
// ============================================================================
// Module   : rr_pick3
// Brief    : Combinational 3-way round-robin picker starting after last.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick3
  import wb_bus_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [1:0]         last,
  output logic [1:0]         winner,
  output logic               any
);

  logic [1:0] w_c1;
  logic [1:0] w_c2;

  // Search order is last+1, last+2, last (mod 3)
  always_comb begin
    w_c1 = (last == SEL_I3) ? SEL_I1 : last + 2'd1;
    w_c2 = (last == SEL_I1) ? SEL_I3 : last - 2'd1;
    any  = |req;
    if (req[w_c1])      winner = w_c1;
    else if (req[w_c2]) winner = w_c2;
    else if (req[last]) winner = last;
    else                winner = w_c1;
  end

endmodule

`default_nettype wire

// File: rtl/wb_bus_arbiter.sv
// ============================================================================
// Module   : wb_bus_arbiter
// Brief    : Round-robin owner of the 3:1 write-back mux with hold-time limit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_bus_arbiter
  import wb_bus_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned HOLD_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] req,
  input  logic [NUM_SRC-1:0] done,
  output logic [NUM_SRC-1:0] gnt,
  output logic [1:0]         sel,
  output logic               bus_valid,
  output logic               timeout
);

  localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(MAX_HOLD - 1);

  logic              r_state;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [1:0]        r_last_owner;

  logic [1:0]        w_winner;
  logic              w_any;
  logic              w_own_done;
  logic              w_own_drop;
  logic              w_at_limit;

  rr_pick3 u_pick (
    .req    (req),
    .last   (r_last_owner),
    .winner (w_winner),
    .any    (w_any)
  );

  assign w_own_done = done[r_last_owner];
  assign w_own_drop = ~req[r_last_owner];
  assign w_at_limit = (r_hold_cnt == c_hold_last);
  assign bus_valid  = |gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_hold_cnt   <= '0;
      r_last_owner <= SEL_I3;
      gnt          <= '0;
      sel          <= SEL_I1;
      timeout      <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            gnt          <= onehot3(w_winner);
            sel          <= w_winner;
            r_last_owner <= w_winner;
            r_hold_cnt   <= '0;
            r_state      <= BUSY;
          end
        end
        BUSY: begin
          // sel is left alone on release so the mux never glitches between owners
          if (w_own_done || w_own_drop || w_at_limit) begin
            gnt     <= '0;
            r_state <= IDLE;
            timeout <= w_at_limit && !w_own_done && !w_own_drop;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_bus_arbiter.sv
// ============================================================================
// Module   : tb_wb_bus_arbiter
// Brief    : Directed scoreboard bench for the write-back bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_bus_arbiter;

  typedef struct packed {
    logic [2:0] gnt;
    logic [1:0] sel;
    logic       tmo;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] req;
  logic [2:0] done;
  logic [2:0] gnt;
  logic [1:0] sel;
  logic       bus_valid;
  logic       timeout;

  int checks;
  int errors;
  exp_t sb_q[$];

  wb_bus_arbiter #(.MAX_HOLD(8), .HOLD_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .sel       (sel),
    .bus_valid (bus_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Structural invariants sampled away from the active edge every cycle
  always @(negedge clk) begin
    checks = checks + 1;
    assert ((sel !== 2'b11) && ($countones(gnt) <= 1) && (bus_valid === |gnt))
    else begin
      errors = errors + 1;
      $error("FAIL invariant: gnt=%b sel=%b bus_valid=%b required one-hot/zero gnt, sel!=11, bus_valid=|gnt",
             gnt, sel, bus_valid);
    end
  end

  task automatic check_out(input string tag, input exp_t e);
    checks = checks + 1;
    assert (gnt === e.gnt && sel === e.sel && timeout === e.tmo && bus_valid === |e.gnt)
    else begin
      errors = errors + 1;
      $error("FAIL %s: observed gnt=%b sel=%b timeout=%b bus_valid=%b expected gnt=%b sel=%b timeout=%b",
             tag, gnt, sel, timeout, bus_valid, e.gnt, e.sel, e.tmo);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then compare
  task automatic cyc(input string tag, input logic [2:0] r, input logic [2:0] d,
                     input logic [2:0] eg, input logic [1:0] es, input logic et);
    exp_t e;
    req  = r;
    done = d;
    sb_q.push_back('{gnt: eg, sel: es, tmo: et});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_out(tag, e);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    req    = 3'b111;
    done   = 3'b000;

    #1;
    check_out("reset_state", '{gnt: 3'b000, sel: 2'b00, tmo: 1'b0});
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // First arbitration after reset starts at source 0
    cyc("first_grant", 3'b111, 3'b000, 3'b001, 2'b00, 1'b0);
    cyc("nonowner_done_a", 3'b111, 3'b110, 3'b001, 2'b00, 1'b0);
    cyc("nonowner_done_b", 3'b111, 3'b110, 3'b001, 2'b00, 1'b0);
    cyc("req_drop_release", 3'b110, 3'b000, 3'b000, 2'b00, 1'b0);
    cyc("idle_done_ignored", 3'b000, 3'b111, 3'b000, 2'b00, 1'b0);

    // Single requester, done on third grant cycle
    cyc("single_grant", 3'b010, 3'b000, 3'b010, 2'b01, 1'b0);
    cyc("single_hold1", 3'b010, 3'b000, 3'b010, 2'b01, 1'b0);
    cyc("single_hold2", 3'b010, 3'b000, 3'b010, 2'b01, 1'b0);
    cyc("single_done", 3'b010, 3'b010, 3'b000, 2'b01, 1'b0);
    cyc("single_idle", 3'b000, 3'b000, 3'b000, 2'b01, 1'b0);

    // All requesting, done on each grant's first cycle: rotation from last=1
    cyc("rr_g2", 3'b111, 3'b000, 3'b100, 2'b10, 1'b0);
    cyc("rr_r2", 3'b111, 3'b100, 3'b000, 2'b10, 1'b0);
    cyc("rr_g0", 3'b111, 3'b000, 3'b001, 2'b00, 1'b0);
    cyc("rr_r0", 3'b111, 3'b001, 3'b000, 2'b00, 1'b0);
    cyc("rr_g1", 3'b111, 3'b000, 3'b010, 2'b01, 1'b0);
    cyc("rr_r1", 3'b111, 3'b010, 3'b000, 2'b01, 1'b0);
    cyc("rr_g2b", 3'b111, 3'b000, 3'b100, 2'b10, 1'b0);
    cyc("rr_r2b", 3'b111, 3'b100, 3'b000, 2'b10, 1'b0);
    cyc("rr_g0b", 3'b111, 3'b000, 3'b001, 2'b00, 1'b0);
    cyc("rr_r0b", 3'b111, 3'b001, 3'b000, 2'b00, 1'b0);

    // Hold limit: 8 grant cycles, then timeout pulse on the idle cycle
    cyc("lim_grant", 3'b100, 3'b000, 3'b100, 2'b10, 1'b0);
    for (int i = 0; i < 7; i++)
      cyc("lim_hold", 3'b100, 3'b000, 3'b100, 2'b10, 1'b0);
    cyc("lim_release", 3'b100, 3'b000, 3'b000, 2'b10, 1'b1);
    cyc("lim_regrant", 3'b100, 3'b000, 3'b100, 2'b10, 1'b0);

    // done coinciding with the limit: no timeout
    for (int i = 0; i < 7; i++)
      cyc("lim_done_hold", 3'b100, 3'b000, 3'b100, 2'b10, 1'b0);
    cyc("lim_done_release", 3'b100, 3'b100, 3'b000, 2'b10, 1'b0);

    // req drop coinciding with the limit: no timeout
    cyc("lim_drop_grant", 3'b100, 3'b000, 3'b100, 2'b10, 1'b0);
    for (int i = 0; i < 7; i++)
      cyc("lim_drop_hold", 3'b100, 3'b000, 3'b100, 2'b10, 1'b0);
    cyc("lim_drop_release", 3'b000, 3'b000, 3'b000, 2'b10, 1'b0);
    cyc("lim_drop_idle", 3'b000, 3'b000, 3'b000, 2'b10, 1'b0);

    // Asynchronous reset while busy
    cyc("async_grant", 3'b010, 3'b000, 3'b010, 2'b01, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_reset", '{gnt: 3'b000, sel: 2'b00, tmo: 1'b0});
    @(posedge clk);
    #1;
    check_out("reset_held", '{gnt: 3'b000, sel: 2'b00, tmo: 1'b0});
    rst_n = 1'b1;
    cyc("post_reset_grant", 3'b110, 3'b000, 3'b010, 2'b01, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
